entropy_packer: RTL and testbench



---
 rtl/entropy_packer_if.sv | 50 +++++
 rtl/entropy_packer.sv | 173 +++++++++++++++++
 tb/tb_entropy_packer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/entropy_packer_if.sv
// ----------------------------------------------------------------------------
// entropy_packer_if
//
// Purpose:
//   Groups the two valid/ready streams around the entropy packer: the narrow
//   entropy-word stream coming in and the wide randomness bundle going out.
//
// Signals:
//   ent_data_i    WORD_W  raw entropy word
//   ent_valid_i   1       ent_data_i valid
//   ent_ready_o   1       packer accepts a word this cycle
//   rand_o        OUT_W   packed randomness bundle
//   rand_valid_o  1       rand_o complete and stable
//   rand_ready_i  1       consumer takes the bundle
//
// Modports:
//   slave  - the packer side
//   master - the environment side (entropy source plus randomness consumer)
// ----------------------------------------------------------------------------
interface entropy_packer_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 108
);
    localparam int OUT_W = WORD_W * NUM_WORDS;

    logic [WORD_W-1:0] ent_data_i;
    logic              ent_valid_i;
    logic              ent_ready_o;
    logic [OUT_W-1:0]  rand_o;
    logic              rand_valid_o;
    logic              rand_ready_i;

    modport slave (
        input  ent_data_i,
        input  ent_valid_i,
        output ent_ready_o,
        output rand_o,
        output rand_valid_o,
        input  rand_ready_i
    );

    modport master (
        output ent_data_i,
        output ent_valid_i,
        input  ent_ready_o,
        input  rand_o,
        input  rand_valid_o,
        output rand_ready_i
    );
endinterface

// File: rtl/entropy_packer.sv
// ----------------------------------------------------------------------------
// entropy_packer
//
// Purpose:
//   Packs NUM_WORDS narrow entropy words into one wide randomness bundle for
//   the masking-randomness consumer, while running a continuous
//   repetition-count health test on every accepted word. A tripped test
//   discards the partial bundle and parks the block until clear_fail_i.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high reset
//   bus            entropy_packer_if.slave (entropy in / bundle out handshakes)
//   fill_level_o   words accepted into the current bundle (0..NUM_WORDS)
//   health_fail_o  sticky repetition-test failure
//   clear_fail_i   clears health_fail_o and restarts filling
//
// All outputs come from registers or from the state register only.
// ----------------------------------------------------------------------------
module entropy_packer #(
    parameter  int WORD_W    = 32,
    parameter  int NUM_WORDS = 108,
    parameter  int REP_LIMIT = 4,
    localparam int OUT_W     = WORD_W * NUM_WORDS,
    localparam int FILL_W    = $clog2(NUM_WORDS + 1),
    localparam int REP_W     = $clog2(REP_LIMIT)
) (
    input  logic              clk,
    input  logic              reset,
    entropy_packer_if.slave   bus,
    output logic [FILL_W-1:0] fill_level_o,
    output logic              health_fail_o,
    input  logic              clear_fail_i
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        FAIL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              run_q;        // low only in the cycle after a reset edge
    logic [OUT_W-1:0]  rand_q;
    logic [FILL_W-1:0] fill_q;
    logic [WORD_W-1:0] prev_word_q;
    logic              prev_valid_q;
    logic [REP_W-1:0]  rep_cnt_q;

    logic              ent_ready;
    logic              accept;
    logic              repeat_hit;
    logic [REP_W-1:0]  rep_cnt_d;
    logic              trip;
    logic              last_word;

    // ------------------------------------------------------------------
    // Decoded handshake and health-test terms
    // ------------------------------------------------------------------
    assign ent_ready  = run_q && (state_q == FILL);
    assign accept     = bus.ent_valid_i && ent_ready;
    assign repeat_hit = prev_valid_q && (bus.ent_data_i == prev_word_q);
    // rep_cnt never exceeds REP_LIMIT-1: reaching it trips the test.
    assign rep_cnt_d  = repeat_hit ? rep_cnt_q + 1'b1 : '0;
    assign trip       = accept && (rep_cnt_d == REP_W'(REP_LIMIT - 1));
    assign last_word  = (fill_q == FILL_W'(NUM_WORDS - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (trip) begin
                    state_d = FAIL;
                end else if (accept && last_word) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.rand_ready_i) begin
                    state_d = FILL;
                end
            end
            FAIL: begin
                if (clear_fail_i) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Bundle storage, fill counter and health-test history
    // ------------------------------------------------------------------
    // NOTE: the bundle register is reset and cleared explicitly because stale
    // randomness must never be handed to the consumer twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q        <= 1'b0;
            rand_q       <= '0;
            fill_q       <= '0;
            prev_word_q  <= '0;
            prev_valid_q <= 1'b0;
            rep_cnt_q    <= '0;
        end else begin
            run_q <= 1'b1;
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        // History spans bundle boundaries; it is only
                        // forgotten by reset or by clearing a failure.
                        prev_word_q  <= bus.ent_data_i;
                        prev_valid_q <= 1'b1;
                        rep_cnt_q    <= rep_cnt_d;
                        if (trip) begin
                            // The offending word is dropped with the partial bundle.
                            rand_q <= '0;
                            fill_q <= '0;
                        end else begin
                            for (int k = 0; k < NUM_WORDS; k++) begin
                                if (fill_q == FILL_W'(k)) begin
                                    rand_q[k*WORD_W +: WORD_W] <= bus.ent_data_i;
                                end
                            end
                            fill_q <= fill_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.rand_ready_i) begin
                        rand_q <= '0;
                        fill_q <= '0;
                    end
                end
                FAIL: begin
                    if (clear_fail_i) begin
                        prev_valid_q <= 1'b0;
                        rep_cnt_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ent_ready_o  = ent_ready;
    assign bus.rand_o       = rand_q;
    assign bus.rand_valid_o = (state_q == FULL);
    assign fill_level_o     = fill_q;
    assign health_fail_o    = (state_q == FAIL);

endmodule

// File: tb/tb_entropy_packer.sv
// ----------------------------------------------------------------------------
// tb_entropy_packer
//
// Three packers side by side:
//   u_a : NUM_WORDS=4,   REP_LIMIT=4   (bundle forming, hold, consume, reset)
//   u_b : NUM_WORDS=4,   REP_LIMIT=3   (health test, clear, cross-bundle runs)
//   u_d : NUM_WORDS=108, REP_LIMIT=4   (random traffic against a queue model)
// ----------------------------------------------------------------------------
module tb_entropy_packer;

    localparam int SN = 4;
    localparam int DN = 108;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       clr_a, clr_b, clr_d;
    logic [2:0] fill_a, fill_b;
    logic [6:0] fill_d;
    logic       hf_a, hf_b, hf_d;

    entropy_packer_if #(.WORD_W(32), .NUM_WORDS(SN)) if_a ();
    entropy_packer_if #(.WORD_W(32), .NUM_WORDS(SN)) if_b ();
    entropy_packer_if #(.WORD_W(32), .NUM_WORDS(DN)) if_d ();

    entropy_packer #(.WORD_W(32), .NUM_WORDS(SN), .REP_LIMIT(4)) u_a (
        .clk(clk), .reset(reset), .bus(if_a.slave),
        .fill_level_o(fill_a), .health_fail_o(hf_a), .clear_fail_i(clr_a)
    );
    entropy_packer #(.WORD_W(32), .NUM_WORDS(SN), .REP_LIMIT(3)) u_b (
        .clk(clk), .reset(reset), .bus(if_b.slave),
        .fill_level_o(fill_b), .health_fail_o(hf_b), .clear_fail_i(clr_b)
    );
    entropy_packer #(.WORD_W(32), .NUM_WORDS(DN), .REP_LIMIT(4)) u_d (
        .clk(clk), .reset(reset), .bus(if_d.slave),
        .fill_level_o(fill_d), .health_fail_o(hf_d), .clear_fail_i(clr_d)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit past the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] d,
                         input logic rr, input logic cf);
        if (sel == 0) begin
            if_a.ent_valid_i = v; if_a.ent_data_i = d; if_a.rand_ready_i = rr; clr_a = cf;
        end else begin
            if_b.ent_valid_i = v; if_b.ent_data_i = d; if_b.rand_ready_i = rr; clr_b = cf;
        end
    endtask

    task automatic check_state(input string tag, input int sel, input logic rdy,
                               input logic vld, input logic [2:0] fill,
                               input logic hf, input logic [127:0] rnd);
        logic         o_rdy, o_vld, o_hf;
        logic [2:0]   o_fill;
        logic [127:0] o_rnd;
        if (sel == 0) begin
            o_rdy = if_a.ent_ready_o; o_vld = if_a.rand_valid_o;
            o_fill = fill_a; o_hf = hf_a; o_rnd = if_a.rand_o;
        end else begin
            o_rdy = if_b.ent_ready_o; o_vld = if_b.rand_valid_o;
            o_fill = fill_b; o_hf = hf_b; o_rnd = if_b.rand_o;
        end
        check({tag, ".ready"}, 128'(o_rdy), 128'(rdy));
        check({tag, ".valid"}, 128'(o_vld), 128'(vld));
        check({tag, ".fill"},  128'(o_fill), 128'(fill));
        check({tag, ".health"}, 128'(o_hf), 128'(hf));
        check({tag, ".rand"},  o_rnd, rnd);
    endtask

    // Push n words (lane i of b) with valid held high, then drop valid.
    task automatic push_words(input int sel, input logic [127:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b1, b[i*32 +: 32], 1'b0, 1'b0);
            cycle();
        end
        drive(sel, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input int sel, input logic rr, input logic cf);
        drive(sel, 1'b0, 32'h0, rr, cf);
        cycle();
        drive(sel, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] b1, b2, b3, b4;
        logic [31:0]  q[$];
        bit           m_full, checked, have_last;
        logic [31:0]  last_acc, dd;
        logic         dv, drr;
        int           bundles, cycles;

        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
        if_d.ent_valid_i = 1'b0; if_d.ent_data_i = '0; if_d.rand_ready_i = 1'b0; clr_d = 1'b0;

        // ---------------- reset state ----------------
        cycle();
        cycle();
        check_state("rst_a", 0, 1'b0, 1'b0, 3'd0, 1'b0, 128'h0);
        check_state("rst_b", 1, 1'b0, 1'b0, 3'd0, 1'b0, 128'h0);
        check("rst_d.ready", 128'(if_d.ent_ready_o), 128'(0));
        reset = 1'b0;
        cycle();
        check_state("run_a", 0, 1'b1, 1'b0, 3'd0, 1'b0, 128'h0);
        check("run_d.ready", 128'(if_d.ent_ready_o), 128'(1));

        // ---------------- bundle forming ----------------
        b1 = 128'h44444444_33333333_22222222_11111111;
        push_words(0, b1, 4);
        check_state("full_a", 0, 1'b0, 1'b1, 3'd4, 1'b0, b1);

        // Hold for 10 cycles: bundle must stay put; extra words are refused.
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, 32'hdeadbeef, 1'b0, 1'b0);
            cycle();
            check("hold_a.rand", if_a.rand_o, b1);
            check("hold_a.valid", 128'(if_a.rand_valid_o), 128'(1));
        end
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
        pulse(0, 1'b1, 1'b0);
        check_state("consume_a", 0, 1'b1, 1'b0, 3'd0, 1'b0, 128'h0);

        // rand_ready_i / clear_fail_i outside their states are ignored.
        push_words(0, 128'h55555555, 1);
        check_state("one_a", 0, 1'b1, 1'b0, 3'd1, 1'b0, 128'h55555555);
        pulse(0, 1'b1, 1'b1);
        check_state("ignore_a", 0, 1'b1, 1'b0, 3'd1, 1'b0, 128'h55555555);

        // ---------------- reset mid-fill ----------------
        push_words(0, 128'h66666666, 1);
        check("two_a.fill", 128'(fill_a), 128'(2));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_state("midrst_a", 0, 1'b0, 1'b0, 3'd0, 1'b0, 128'h0);
        cycle();
        b2 = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
        push_words(0, b2, 4);
        check_state("postrst_a", 0, 1'b0, 1'b1, 3'd4, 1'b0, b2);
        pulse(0, 1'b1, 1'b0);

        // ---------------- health test (REP_LIMIT=3) ----------------
        push_words(1, 128'h0000000a_0000000a, 2);
        check_state("rep2_b", 1, 1'b1, 1'b0, 3'd2, 1'b0, 128'h0000000a_0000000a);
        push_words(1, 128'h0000000a, 1);
        check_state("trip_b", 1, 1'b0, 1'b0, 3'd0, 1'b1, 128'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 32'h1234, 1'b1, 1'b0);
            cycle();
            check("failhold_b.ready", 128'(if_b.ent_ready_o), 128'(0));
            check("failhold_b.health", 128'(hf_b), 128'(1));
        end
        pulse(1, 1'b0, 1'b1);
        check_state("clear_b", 1, 1'b1, 1'b0, 3'd0, 1'b0, 128'h0);
        // History was cleared, so a fourth 0xA right away is fine.
        b3 = 128'h0000000d_0000000c_0000000b_0000000a;
        push_words(1, b3, 4);
        check_state("afterclr_b", 1, 1'b0, 1'b1, 3'd4, 1'b0, b3);
        pulse(1, 1'b1, 1'b0);

        // Repetition spanning a bundle boundary: 1,2,3,5 | 5,5 trips.
        b4 = 128'h00000005_00000003_00000002_00000001;
        push_words(1, b4, 4);
        check_state("span1_b", 1, 1'b0, 1'b1, 3'd4, 1'b0, b4);
        pulse(1, 1'b1, 1'b0);
        push_words(1, 128'h5, 1);
        check_state("span2_b", 1, 1'b1, 1'b0, 3'd1, 1'b0, 128'h5);
        push_words(1, 128'h5, 1);
        check_state("span3_b", 1, 1'b0, 1'b0, 3'd0, 1'b1, 128'h0);
        pulse(1, 1'b0, 1'b1);

        // ---------------- random traffic, default parameters ----------------
        m_full = 1'b0; checked = 1'b0; have_last = 1'b0; last_acc = '0;
        bundles = 0; cycles = 0;
        while (bundles < 20 && cycles < 20000) begin
            dv  = ($urandom_range(0, 1) == 1);
            drr = ($urandom_range(0, 2) == 0);
            dd  = $urandom;
            if (have_last && dd == last_acc) dd = ~dd;
            if_d.ent_valid_i = dv; if_d.ent_data_i = dd; if_d.rand_ready_i = drr;
            cycle();
            cycles++;
            // Model: collect words until the bundle is full, then wait for a take.
            if (!m_full) begin
                if (dv) begin
                    q.push_back(dd);
                    last_acc = dd; have_last = 1'b1;
                    if (q.size() == DN) begin
                        m_full = 1'b1; checked = 1'b0;
                    end
                end
            end else if (drr) begin
                q.delete();
                m_full = 1'b0;
                bundles++;
            end
            check("rnd.ready", 128'(if_d.ent_ready_o), 128'(!m_full));
            check("rnd.valid", 128'(if_d.rand_valid_o), 128'(m_full));
            check("rnd.fill", 128'(fill_d), 128'(m_full ? DN : q.size()));
            if (m_full && !checked) begin
                for (int k = 0; k < DN; k++) begin
                    check($sformatf("rnd.word%0d", k), 128'(if_d.rand_o[k*32 +: 32]), 128'(q[k]));
                end
                check("rnd.health", 128'(hf_d), 128'(0));
                checked = 1'b1;
            end
        end
        if_d.ent_valid_i = 1'b0; if_d.rand_ready_i = 1'b0;
        check("rnd.bundles", 128'(bundles), 128'(20));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
